// File: rtl/sudoku_pkg.sv
// Shared constants, step-state encoding and cell-addressing helpers for the
// sudoku pipeline stages.
package sudoku_pkg;

    localparam int N      = 9;
    localparam int CELLS  = N * N;
    localparam int CELL_W = 4;
    localparam int GRID_W = CELLS * CELL_W;
    localparam int IDX_W  = 7;
    localparam int RC_W   = 4;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } step_state_t;

    function automatic logic [IDX_W-1:0] cell_index(input logic [RC_W-1:0] row,
                                                    input logic [RC_W-1:0] col);
        return IDX_W'(row) * IDX_W'(N) + IDX_W'(col);
    endfunction

    // 81:1 nibble mux; a constant-index loop keeps the part-selects static.
    function automatic logic [CELL_W-1:0] cell_nibble(input logic [GRID_W-1:0] g,
                                                      input logic [IDX_W-1:0] idx);
        logic [CELL_W-1:0] nib;
        nib = '0;
        for (int k = 0; k < CELLS; k++) begin
            if (idx == IDX_W'(k)) nib = g[k*CELL_W +: CELL_W];
        end
        return nib;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronizer, stable-count debounce and a
// one-cycle pulse on each debounced rising edge.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            // cnt tracks consecutive samples that disagree with the current level
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/grid_cell_stepper.sv
// Display stage: snapshots the solved grid and steps row/column/digit out
// one cell per debounced button press.
module grid_cell_stepper
    import sudoku_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              solved,
    input  logic [GRID_W-1:0] grid,
    input  logic              next,
    output logic [3:0]        D1,
    output logic [3:0]        D2,
    output logic [3:0]        D3,
    output logic              shown_all,
    output logic              busy
);

    step_state_t       state;
    step_state_t       state_nxt;
    logic [RC_W-1:0]   row;
    logic [RC_W-1:0]   col;
    logic [RC_W-1:0]   row_nxt;
    logic [RC_W-1:0]   col_nxt;
    logic [GRID_W-1:0] snap;
    logic [GRID_W-1:0] snap_nxt;
    logic [CELL_W-1:0] nib_nxt;
    logic              press;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .reset(reset),
        .raw  (next),
        .press(press)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        snap_nxt  = snap;
        case (state)
            // a press coinciding with capture is deliberately dropped here
            WAIT: begin
                if (solved) begin
                    snap_nxt  = grid;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (press) begin
                    if (row == RC_W'(N - 1) && col == RC_W'(N - 1)) begin
                        state_nxt = DONE;
                    end else if (col == RC_W'(N - 1)) begin
                        col_nxt = '0;
                        row_nxt = row + 1'b1;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            DONE: begin
                if (press) begin
                    row_nxt   = '0;
                    col_nxt   = '0;
                    state_nxt = SHOW;
                end
            end
            default: state_nxt = WAIT;
        endcase
        nib_nxt = cell_nibble(snap_nxt, cell_index(row_nxt, col_nxt));
    end

    // Outputs are driven from next-state values so they land on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            snap      <= '0;
            D1        <= '0;
            D2        <= '0;
            D3        <= '0;
            busy      <= 1'b0;
            shown_all <= 1'b0;
        end else begin
            row  <= row_nxt;
            col  <= col_nxt;
            snap <= snap_nxt;
            if (state_nxt != WAIT) begin
                D1 <= row_nxt + 1'b1;
                D2 <= col_nxt + 1'b1;
                D3 <= nib_nxt;
            end
            busy      <= (state_nxt == SHOW);
            shown_all <= (state_nxt == DONE);
        end
    end

endmodule

// File: doc/grid_cell_stepper.md
Name: grid_cell_stepper

Overview:
- Downstream display stage after the naked-pairs solver.
- Captures the solver's 324-bit grid (81 cells × 4 bits) once the solver reports completion.
- Steps through the grid one cell per debounced "next" press, driving row, column and digit to the three 4-bit display outputs.
- Flags when the last cell has been shown.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before the debounced next level changes.
- N, 9: grid side; cells = N*N.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- solved  input  1  solver completion level (solver's alldone).
- grid  input  324  solver grid; cell k = row*9+col (0-based) at bits [4k+3:4k].
- next  input  1  raw asynchronous push-button.
- D1  output  4  displayed row, 1..9.
- D2  output  4  displayed column, 1..9.
- D3  output  4  displayed digit, raw cell nibble.
- shown_all  output  1  high after the last cell (9,9) has been stepped past.
- busy  output  1  high in SHOW state.

Behaviour:
- Reset (synchronous, active-high): D1=D2=D3=0, shown_all=0, busy=0, state=WAIT, snapshot=0, debounce state cleared. Reset mid-operation aborts everything and returns to WAIT on the next edge.
- Button path:
  - 2-flop synchronizer on next.
  - Debounce counter: the debounced level takes the synchronized value only after DEBOUNCE_CYCLES consecutive equal samples. Any differing sample restarts the count.
  - A 1-cycle "press" pulse is generated on the debounced 0→1 transition.
  - Latency: with next held at 1, D1..D3 update on rising edge DEBOUNCE_CYCLES+3 after the first edge sampling next=1.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no press.
- State WAIT:
  - Press ignored.
  - When solved=1, capture grid into the snapshot register on that edge and go to SHOW.
  - On the next edge: D1=1, D2=1, D3=snapshot cell 0, busy=1.
- State SHOW:
  - Press advances the column: col 9 wraps to 1 and row increments.
  - D3 is always the snapshot nibble of the current cell. Outputs are registered.
  - solved falling or grid changing has no effect; the snapshot is held.
  - Press while at (9,9): go to DONE, shown_all=1, busy=0, D1..D3 hold at (9,9,digit).
- State DONE:
  - A press restarts at (1,1): shown_all=0, busy=1, state=SHOW, same snapshot, no recapture.
  - To recapture, reset is required.
- Press and solved rising on the same edge in WAIT: capture only; the press is discarded.
- Nibble values 0 or >9 are passed through unchanged on D3 (no checking).
- Internal index: row/col counters 0..8, +1 offset on output; the 81:1 nibble mux is indexed by row*9+col (7 bits).

Decomposition:
- Shared package sudoku_pkg holds:
  - Constants: N=9, CELLS=81, CELL_W=4, GRID_W=324.
  - State encoding: WAIT, SHOW, DONE.
  - Function cell_index(row,col).
- Sub-module button_conditioner (synchronizer + debounce + rising-edge pulse), parameterised by DEBOUNCE_CYCLES. It is reusable by other stages that use next.

Test Plan:
- Reset pulse, solved=0, next toggled → D1..D3=0, shown_all=0, busy=0 throughout; presses ignored.
- grid cell k=(k%9)+1, solved=1 → one edge later D1=1, D2=1, D3=1, busy=1; grid then changed to all-zero → D3 unchanged.
- Nine clean presses (each held 20 cycles) → D2 goes 2..9, then the 9th press gives D1=2, D2=1, D3=1; check each update lands exactly DEBOUNCE_CYCLES+3 edges after next rises.
- 1- and 3-cycle glitches on next with DEBOUNCE_CYCLES=4 → no advance.
- 80 presses → (9,9) with D3=9; 81st press → shown_all=1, busy=0, outputs hold; 82nd press → (1,1), shown_all=0.
- Reset asserted for 1 cycle mid-SHOW at (4,5) → all outputs 0, state WAIT; reasserting solved recaptures and shows (1,1).
